// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit (MULT, MULTU, DIV, DIVU) returning {hi, lo}.
// Optional single-cycle multiplier selected by defining MULDIV_FAST_MUL_EN.
module muldiv_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o,
  output logic                 busy_o,
  output logic                 stallreq_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned RES_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RES_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               is_div_q, is_div_d;
  logic               neg_lo_q, neg_lo_d;
  logic               neg_hi_q, neg_hi_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic               signed_op, is_div_op, sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic [WIDTH:0]     div_partial;
  logic [WIDTH+1:0]   div_trial;
  logic [RES_W-1:0]   div_step, step, fix;
  logic [WIDTH-1:0]   fix_hi, fix_lo;
`ifdef MULDIV_FAST_MUL_EN
  logic [RES_W-1:0]   fast_prod;
`else
  logic [WIDTH:0]     mul_sum;
  logic [RES_W-1:0]   mul_step;
`endif

  // Operand decode: signed ops work on magnitudes
  always_comb begin
    signed_op = ~op_i[0];
    is_div_op = op_i[1];
    sign1     = signed_op & opdata1_i[WIDTH-1];
    sign2     = signed_op & opdata2_i[WIDTH-1];
    mag1      = sign1 ? (WIDTH'(0) - opdata1_i) : opdata1_i;
    mag2      = sign2 ? (WIDTH'(0) - opdata2_i) : opdata2_i;
  end

  // One iteration of the datapath plus the final sign fix-up
  always_comb begin
    div_partial = {acc_q[RES_W-1:WIDTH], acc_q[WIDTH-1]};
    div_trial   = {1'b0, div_partial} - {2'b00, opb_q};
    if (div_trial[WIDTH+1]) begin
      div_step = {div_partial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else begin
      div_step = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = RES_W'(mag1) * RES_W'(mag2);
    step      = div_step;
`else
    mul_sum   = {1'b0, acc_q[RES_W-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : WIDTH'(0))};
    mul_step  = {mul_sum, acc_q[WIDTH-1:1]};
    step      = is_div_q ? div_step : mul_step;
`endif
    fix_hi = neg_hi_q ? (WIDTH'(0) - step[RES_W-1:WIDTH]) : step[RES_W-1:WIDTH];
    fix_lo = neg_lo_q ? (WIDTH'(0) - step[WIDTH-1:0]) : step[WIDTH-1:0];
    if (is_div_q) begin
      fix = {fix_hi, fix_lo};
    end else begin
      fix = neg_lo_q ? (RES_W'(0) - step) : step;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          acc_d    = {WIDTH'(0), mag1};
          opb_d    = mag2;
          is_div_d = is_div_op;
          neg_lo_d = sign1 ^ sign2;
          neg_hi_d = sign1;
          cnt_d    = '0;
          if (is_div_op && (opdata2_i == '0)) begin
            result_d = {opdata1_i, {WIDTH{1'b1}}};
            state_d  = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div_op) begin
            result_d = (sign1 ^ sign2) ? (RES_W'(0) - fast_prod) : fast_prod;
            state_d  = S_DONE;
`endif
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_d = fix;
            state_d  = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_DONE);
    busy_d  = (state_d == S_CALC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      result_q <= result_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
    end
  end

  assign result_o   = result_q;
  assign ready_o    = ready_q;
  assign busy_o     = busy_q;
  assign stallreq_o = (start_i & ~ready_q) | busy_q;

endmodule
